// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects and MDU FSM states.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_busy_tracker.sv
// Tracks multiply/divide occupancy: IDLE/BUSY FSM with a down-counter of MDU_LAT cycles.
module mdu_busy_tracker
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam logic [7:0] LOAD_VAL = 8'(MDU_LAT - 1);

    mdu_state_t state_r, state_s;
    logic [7:0] cnt_r, cnt_s;

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MDU_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: starts are only honoured from IDLE, so a start on the final BUSY cycle is dropped.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            MDU_IDLE: begin
                if (start) begin
                    state_s = MDU_BUSY;
                    cnt_s   = LOAD_VAL;
                end else begin
                    state_s = MDU_IDLE;
                    cnt_s   = 8'd0;
                end
            end
            MDU_BUSY: begin
                if (cnt_r == 8'd0) begin
                    state_s = MDU_IDLE;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = MDU_BUSY;
                    cnt_s   = cnt_r - 8'd1;
                end
            end
            default: begin
                state_s = MDU_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    assign busy = (state_r == MDU_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard detection and forwarding control with MDU occupancy tracking.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MDU_LAT    = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rt_e,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    input  logic [REG_ADDR_W-1:0] write_reg_m,
    input  logic [REG_ADDR_W-1:0] write_reg_w,
    input  logic                  reg_write_e,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic                  mem_to_reg_e,
    input  logic                  mem_to_reg_m,
    input  logic                  branch_d,
    input  logic                  jump_d,
    input  logic                  mdu_op_d,
    input  logic                  hilo_rd_d,
    input  logic                  mdu_start_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_e,
    output logic                  fwd_a_d,
    output logic                  fwd_b_d,
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e,
    output logic                  mdu_busy,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic       lw_stall_s, br_stall_s, mdu_stall_s, stall_s;
    logic       e_hit_s, m_hit_s;
    logic [1:0] fwd_a_e_s, fwd_b_e_s;

    mdu_busy_tracker #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_busy_tracker (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_start_e),
        .busy  (mdu_busy)
    );

    // Stall detection; every comparison excludes register 0.
    always_comb begin
        lw_stall_s = mem_to_reg_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));
        e_hit_s    = reg_write_e && (write_reg_e != '0) &&
                     ((write_reg_e == rs_d) || (write_reg_e == rt_d));
        m_hit_s    = mem_to_reg_m && (write_reg_m != '0) &&
                     ((write_reg_m == rs_d) || (write_reg_m == rt_d));
        br_stall_s  = branch_d && (e_hit_s || m_hit_s);
        mdu_stall_s = (mdu_op_d || hilo_rd_d) && (mdu_busy || mdu_start_e);
        stall_s     = lw_stall_s || br_stall_s || mdu_stall_s;
    end

    // Execute forward selects; the Memory result is younger and wins over Writeback.
    always_comb begin
        fwd_a_e_s = FWD_RF;
        fwd_b_e_s = FWD_RF;
        if (reg_write_m && (rs_e != '0) && (rs_e == write_reg_m)) begin
            fwd_a_e_s = FWD_MEM;
        end else if (reg_write_w && (rs_e != '0) && (rs_e == write_reg_w)) begin
            fwd_a_e_s = FWD_WB;
        end else begin
            fwd_a_e_s = FWD_RF;
        end
        if (reg_write_m && (rt_e != '0) && (rt_e == write_reg_m)) begin
            fwd_b_e_s = FWD_MEM;
        end else if (reg_write_w && (rt_e != '0) && (rt_e == write_reg_w)) begin
            fwd_b_e_s = FWD_WB;
        end else begin
            fwd_b_e_s = FWD_RF;
        end
    end

    assign stall_f = stall_s && !rst;
    assign stall_d = stall_s && !rst;
    assign flush_e = (stall_s || jump_d) && !rst;
    assign fwd_a_d = reg_write_m && (rs_d != '0) && (rs_d == write_reg_m) && !rst;
    assign fwd_b_d = reg_write_m && (rt_d != '0) && (rt_d == write_reg_m) && !rst;
    assign fwd_a_e = rst ? FWD_RF : fwd_a_e_s;
    assign fwd_b_e = rst ? FWD_RF : fwd_b_e_s;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (stall_f && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = '0;
`endif

endmodule
